// File: rtl/game_over_overlay.sv
// Game-over text overlay: windows the raster, addresses the text ROM and merges its bit over the background.
// Optional macro GAME_OVER_SCALE2X_EN doubles the window so each ROM bit covers 2x2 pixels.
module game_over_overlay #(
  parameter int          POS_X        = 228,
  parameter int          POS_Y        = 228,
  parameter int          IMG_W        = 184,
  parameter int          IMG_H        = 23,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_RGB       = 12'hF00
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic [11:0] bg_rgb,
  input  logic        game_over,
  input  logic        restart,
  output logic [7:0]  x_count,
  output logic [4:0]  y_count,
  input  logic        data_game_over,
  output logic [11:0] rgb_out,
  output logic        overlay_active
);

`ifdef GAME_OVER_SCALE2X_EN
  localparam int SCALE_SHIFT = 1;
`else
  localparam int SCALE_SHIFT = 0;
`endif

  // 11-bit window bounds so POS+size cannot wrap against the 10-bit raster counters
  localparam logic [10:0] X_LO = 11'(POS_X);
  localparam logic [10:0] X_HI = 11'(POS_X + (IMG_W << SCALE_SHIFT));
  localparam logic [10:0] Y_LO = 11'(POS_Y);
  localparam logic [10:0] Y_HI = 11'(POS_Y + (IMG_H << SCALE_SHIFT));

  localparam int                CNT_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, PENDING, SHOW_ON, SHOW_OFF} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] blink_q, blink_d;

  logic [10:0] h_ext, v_ext, h_off, v_off;
  logic        h_hit, v_hit;
  logic [7:0]  col_idx;
  logic [4:0]  row_idx;
  logic        in_win_d1, video_on_d1;
  logic [11:0] bg_d1;
  logic        visible;

  assign h_ext   = {1'b0, h_count};
  assign v_ext   = {1'b0, v_count};
  assign h_off   = h_ext - X_LO;
  assign v_off   = v_ext - Y_LO;
  assign h_hit   = (h_ext >= X_LO) && (h_ext < X_HI);
  assign v_hit   = (v_ext >= Y_LO) && (v_ext < Y_HI);
  assign col_idx = 8'(h_off >> SCALE_SHIFT);
  assign row_idx = 5'(v_off >> SCALE_SHIFT);
  assign visible = (state_q == SHOW_ON);

  // NOTE: every variable driven here gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    if (restart) begin
      state_d = IDLE;
      blink_d = '0;
    end else begin
      unique case (state_q)
        IDLE:    if (game_over) state_d = PENDING;
        PENDING: if (frame_start) begin
          state_d = SHOW_ON;
          blink_d = '0;
        end
        SHOW_ON, SHOW_OFF: if (frame_start) begin
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            state_d = (state_q == SHOW_ON) ? SHOW_OFF : SHOW_ON;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q        <= IDLE;
      blink_q        <= '0;
      x_count        <= '0;
      y_count        <= '0;
      in_win_d1      <= 1'b0;
      video_on_d1    <= 1'b0;
      bg_d1          <= '0;
      rgb_out        <= '0;
      overlay_active <= 1'b0;
    end else begin
      state_q        <= state_d;
      blink_q        <= blink_d;
      overlay_active <= (state_d == SHOW_ON) || (state_d == SHOW_OFF);

      // Row index is latched once per line so the ROM row is settled before the window opens
      if (h_count == 10'd0) y_count <= v_hit ? row_idx : 5'd0;

      x_count     <= h_hit ? col_idx : 8'd0;
      in_win_d1   <= h_hit && v_hit;
      video_on_d1 <= video_on;
      bg_d1       <= bg_rgb;

      if (!video_on_d1)                             rgb_out <= '0;
      else if (in_win_d1 && visible && data_game_over) rgb_out <= FG_RGB;
      else                                          rgb_out <= bg_d1;
    end
  end

endmodule

// File: tb/tb_game_over_overlay.sv
// Self-checking bench for game_over_overlay: directed scenarios followed by random raster traffic,
// all checked against a frame-counting reference model.
module tb_game_over_overlay;

  localparam int          POS_X = 228;
  localparam int          POS_Y = 228;
  localparam int          IMG_W = 184;
  localparam int          IMG_H = 23;
  localparam int          BLINK = 2;
  localparam logic [11:0] FG    = 12'hF00;
`ifdef GAME_OVER_SCALE2X_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif

  logic        clock_25 = 1'b0;
  logic        reset, video_on, frame_start, game_over, restart, data_game_over;
  logic [9:0]  h_count, v_count;
  logic [11:0] bg_rgb, rgb_out;
  logic [7:0]  x_count;
  logic [4:0]  y_count;
  logic        overlay_active;

  game_over_overlay #(
    .POS_X(POS_X), .POS_Y(POS_Y), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .BLINK_FRAMES(BLINK), .FG_RGB(FG)
  ) dut (
    .clock_25(clock_25), .reset(reset), .h_count(h_count), .v_count(v_count),
    .video_on(video_on), .frame_start(frame_start), .bg_rgb(bg_rgb),
    .game_over(game_over), .restart(restart), .x_count(x_count), .y_count(y_count),
    .data_game_over(data_game_over), .rgb_out(rgb_out), .overlay_active(overlay_active)
  );

  always #20 clock_25 = ~clock_25;

  int vectors = 0, checks = 0, miscompares = 0;

  // Reference model: mode 0 idle, 1 armed, 2 showing; visibility from frames elapsed since showing began
  int          m_mode = 0, m_frames = 0;
  bit          m_vis = 0, m_act = 0, m_vid1 = 0, m_win1 = 0;
  logic [11:0] m_bg1 = '0, m_rgb = '0;
  logic [7:0]  m_x = '0;
  logic [4:0]  m_y = '0;

  function automatic bit in_h(int h);
    return (h >= POS_X) && (h < POS_X + IMG_W * SC);
  endfunction
  function automatic bit in_v(int v);
    return (v >= POS_Y) && (v < POS_Y + IMG_H * SC);
  endfunction

  task automatic model_edge();
    int h, v;
    h = int'(h_count);
    v = int'(v_count);
    if (reset) begin
      m_mode = 0; m_frames = 0; m_vis = 0; m_act = 0;
      m_vid1 = 0; m_win1 = 0; m_bg1 = '0; m_rgb = '0; m_x = '0; m_y = '0;
    end else begin
      if (!m_vid1)                            m_rgb = 12'h000;
      else if (m_win1 && m_vis && data_game_over) m_rgb = FG;
      else                                    m_rgb = m_bg1;
      m_x = in_h(h) ? 8'((h - POS_X) / SC) : 8'd0;
      if (h == 0) m_y = in_v(v) ? 5'((v - POS_Y) / SC) : 5'd0;
      m_vid1 = video_on;
      m_win1 = in_h(h) && in_v(v);
      m_bg1  = bg_rgb;
      if (restart) begin
        m_mode = 0; m_frames = 0;
      end else if (m_mode == 0 && game_over) begin
        m_mode = 1;
      end else if (m_mode == 1 && frame_start) begin
        m_mode = 2; m_frames = 0;
      end else if (m_mode == 2 && frame_start) begin
        m_frames++;
      end
      m_act = (m_mode == 2);
      m_vis = m_act && (((m_frames / BLINK) % 2) == 0);
    end
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply the currently driven inputs for one clock, then compare all outputs with the model
  task automatic cycle();
    @(posedge clock_25);
    model_edge();
    #1;
    vectors++;
    check("x_count", 12'(x_count), 12'(m_x));
    check("y_count", 12'(y_count), 12'(m_y));
    check("rgb_out", rgb_out, m_rgb);
    check("overlay_active", 12'(overlay_active), 12'(m_act));
  endtask

  task automatic run_px(input int v, input int h0, input int n);
    for (int i = 0; i < n; i++) begin
      v_count = 10'(v);
      h_count = 10'(h0 + i);
      bg_rgb  = 12'($urandom);
      cycle();
    end
  endtask

  task automatic pulse_frame();
    h_count = 10'd0; v_count = 10'd0; frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
  endtask

  logic [11:0] bg_hold;

  initial begin
    reset = 1'b1; video_on = 1'b1; frame_start = 1'b0; game_over = 1'b0; restart = 1'b0;
    data_game_over = 1'b1; h_count = 10'd100; v_count = 10'd100; bg_rgb = 12'h0A0;

    // Reset held for three cycles mid-line, then the first cycle after release
    for (int i = 0; i < 3; i++) begin
      h_count = 10'(100 + i);
      cycle();
      check("rst_rgb", rgb_out, 12'h000);
      check("rst_active", 12'(overlay_active), 12'h000);
    end
    reset = 1'b0; h_count = 10'd103;
    cycle();
    check("post_rst_rgb", rgb_out, 12'h000);
    check("post_rst_x", 12'(x_count), 12'h000);
    check("post_rst_y", 12'(y_count), 12'h000);

    // Idle: line 230 passes background straight through, row index loads at h=0
    run_px(230, 0, 6);
    check("idle_y_line230", 12'(y_count), 12'(2 / SC));
    run_px(230, 226, 16);

    // Arm, then enter SHOW_ON at the next frame start
    h_count = 10'd300; v_count = 10'd300; game_over = 1'b1;
    cycle();
    game_over = 1'b0;
    pulse_frame();
    check("armed_active", 12'(overlay_active), 12'h001);
    run_px(228, 0, 2);
    v_count = 10'd228; h_count = 10'd228;
    cycle();
    check("win_x0", 12'(x_count), 12'h000);
    h_count = 10'd229;
    cycle();
    check("win_text", rgb_out, FG);
    run_px(228, 408, 8);

    // Blink: two frames on, two off, on again
    for (int f = 0; f <= 4; f++) begin
      h_count = 10'd0; v_count = 10'd229;
      cycle();
      h_count = 10'd230; bg_hold = 12'($urandom); bg_rgb = bg_hold;
      cycle();
      h_count = 10'd231; bg_rgb = 12'($urandom);
      cycle();
      check("blink_rgb", rgb_out, ((f / 2) % 2 == 0) ? FG : bg_hold);
      check("blink_active", 12'(overlay_active), 12'h001);
      if (f < 4) pulse_frame();
    end

    // Restart and game_over together while showing text
    h_count = 10'd230; v_count = 10'd229; restart = 1'b1; game_over = 1'b1;
    cycle();
    restart = 1'b0; game_over = 1'b0;
    check("restart_active", 12'(overlay_active), 12'h000);
    run_px(229, 231, 4);

    // Blanking while in SHOW_ON
    game_over = 1'b1; cycle(); game_over = 1'b0;
    pulse_frame();
    video_on = 1'b0; h_count = 10'd700; v_count = 10'd229;
    cycle();
    h_count = 10'd701;
    cycle();
    check("blank_rgb", rgb_out, 12'h000);
    video_on = 1'b1;

`ifdef GAME_OVER_SCALE2X_EN
    v_count = 10'd229; h_count = 10'd229;
    cycle();
    check("scale_x229", 12'(x_count), 12'h000);
    h_count = 10'd230;
    cycle();
    check("scale_x230", 12'(x_count), 12'h001);
`endif

    // Random traffic biased toward the window edges
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 499) == 0);
      frame_start    = ($urandom_range(0, 79) == 0);
      game_over      = ($urandom_range(0, 59) == 0);
      restart        = ($urandom_range(0, 199) == 0);
      video_on       = ($urandom_range(0, 4) != 0);
      data_game_over = 1'($urandom);
      bg_rgb         = 12'($urandom);
      case ($urandom_range(0, 9))
        0:       h_count = 10'd0;
        1, 2, 3: h_count = 10'($urandom_range(0, 799));
        default: h_count = 10'($urandom_range(POS_X - 4, POS_X + IMG_W * SC + 4));
      endcase
      if ($urandom_range(0, 2) == 0) v_count = 10'($urandom_range(0, 524));
      else                           v_count = 10'($urandom_range(POS_Y - 3, POS_Y + IMG_H * SC + 3));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_over_overlay.md
Name: game_over_overlay

Overview:
- Pixel-pipeline stage that drives the game-over text ROM and consumes its 1-bit output.
- Takes the VGA raster position and decides whether the current pixel lies inside the 184x23 game-over window. It generates `x_count`/`y_count` for the ROM and merges the returned bit over the background colour.
- A small FSM arms the overlay on `game_over`, shows it with frame-synchronous blinking, and clears it on `restart`.
- Sits between the VGA timing generator / background renderer and the RGB output register.

Parameters:
- `POS_X`, 228, window left edge in pixels; must be >= 2.
- `POS_Y`, 228, window top line.
- `IMG_W`, 184, ROM image width in pixels.
- `IMG_H`, 23, ROM image height in lines.
- `BLINK_FRAMES`, 30, frames per blink phase; must be >= 1.
- `FG_RGB`, 12'hF00, text colour.

Ports:
- `clock_25` in 1 — 25 MHz pixel clock.
- `reset` in 1 — synchronous, active-high.
- `h_count` in 10 — current pixel column, 0..799.
- `v_count` in 10 — current line, 0..524.
- `video_on` in 1 — active-area flag, aligned with `h_count`/`v_count`.
- `frame_start` in 1 — one-cycle pulse at `h_count`=0, `v_count`=0.
- `bg_rgb` in 12 — background colour, aligned with `h_count`.
- `game_over` in 1 — one-cycle pulse from game logic.
- `restart` in 1 — one-cycle pulse from game logic.
- `x_count` out 8 — ROM column index.
- `y_count` out 5 — ROM row index.
- `data_game_over` in 1 — ROM pixel bit.
- `rgb_out` out 12 — final pixel colour.
- `overlay_active` out 1 — high while FSM is in SHOW_ON or SHOW_OFF.

Behaviour:
- Clocking and reset:
  - One clock (`clock_25`); reset is synchronous and active-high (`reset`).
  - All outputs and state are registered.
  - Reset values: `x_count`=0, `y_count`=0, `rgb_out`=0, `overlay_active`=0, FSM=IDLE, blink counter=0, pipeline flags=0.
- Row fetch:
  - On the cycle where `h_count`==0, `y_count` loads `v_count`-`POS_Y` (low 5 bits) if `POS_Y` <= `v_count` < `POS_Y`+`IMG_H`; otherwise it loads 0.
  - `y_count` is then stable for the whole line, so the ROM's registered row has settled long before the window starts (`POS_X` >= 2).
- Column, stage 1 (cycle t+1):
  - `x_count` <= `h_count`-`POS_X` (8 bits) if `POS_X` <= `h_count` < `POS_X`+`IMG_W`, else 0.
  - `in_win_d1` <= horizontal AND vertical window hit.
  - `video_on` and `bg_rgb` are delayed one cycle alongside.
  - `data_game_over` is treated as valid in the same cycle as the registered `x_count`.
- Output, stage 2 (cycle t+2):
  - If `video_on_d1`=0: `rgb_out`=0.
  - Else if `in_win_d1` & `visible` & `data_game_over`: `rgb_out`=`FG_RGB`.
  - Else: `rgb_out`=`bg_d1`.
  - Total latency is 2 cycles from `h_count`/`v_count`/`bg_rgb` to `rgb_out`.
  - Upstream `hsync`/`vsync` must be delayed 2 cycles outside this block.
- Width rule: the comparisons use 11-bit arithmetic, so `POS_X`+`IMG_W` and `POS_Y`+`IMG_H` never overflow.
- FSM states: IDLE, PENDING, SHOW_ON, SHOW_OFF.
  - IDLE -> PENDING on `game_over`.
  - PENDING -> SHOW_ON on `frame_start`; blink counter cleared.
  - SHOW_ON/SHOW_OFF: the blink counter increments on each `frame_start`. When it reaches `BLINK_FRAMES`-1 at a `frame_start`, it clears and the state toggles between SHOW_ON and SHOW_OFF.
  - Any state -> IDLE on `restart`; this takes effect the next cycle even mid-frame.
  - `restart` and `game_over` in the same cycle: `restart` wins and the state goes to IDLE.
  - `game_over` while in PENDING/SHOW_*: ignored; the counter is not reset.
- `visible` = (state==SHOW_ON). It therefore changes only at `frame_start`, except on `restart`. No tearing from blinking.
- `overlay_active` = (state==SHOW_ON || state==SHOW_OFF), registered.
- `reset` mid-frame: the next cycle shows `rgb_out`=0 and the pipeline flags are cleared. Normal output resumes at the first pixel after reset deasserts, plus 2-cycle latency.

Optional Feature:
- Macro `GAME_OVER_SCALE2X_EN`.
- When defined:
  - The window is 2*`IMG_W` x 2*`IMG_H` (368x46) starting at `POS_X`,`POS_Y`.
  - `x_count` = (`h_count`-`POS_X`)>>1 and `y_count` = (`v_count`-`POS_Y`)>>1, so each ROM bit covers 2x2 pixels.
  - Comparisons use 11-bit arithmetic.
- When not defined: 1:1 mapping exactly as in Behaviour.
- Latency and FSM are unchanged either way.

Test Plan:
- Reset asserted for 3 cycles mid-line with `bg_rgb`=12'h0A0 -> `rgb_out`=0, `overlay_active`=0, `x_count`=0, `y_count`=0 during reset and on the cycle after.
- FSM in IDLE, raster scanning line 230 with ROM bit=1 everywhere -> `rgb_out`=`bg_rgb` delayed 2 cycles; `y_count`=2 after `h_count`=0 on that line.
- `game_over` pulse, then `frame_start` -> `overlay_active`=1. At `h_count`=228, `v_count`=228 with ROM bit=1: `x_count`=0 one cycle later and `rgb_out`=12'hF00 two cycles later. At `h_count`=412 (outside the window): `rgb_out`=`bg_rgb`.
- Blink with `BLINK_FRAMES`=2 -> SHOW_ON for frames 0-1, SHOW_OFF for frames 2-3, SHOW_ON again at frame 4. Text is absent during SHOW_OFF while `overlay_active` stays 1.
- `restart` and `game_over` in the same cycle while in SHOW_ON -> IDLE next cycle. `overlay_active`=0; text pixels revert to `bg_rgb` within 2 cycles.
- `video_on`=0 (`h_count`=700) while in SHOW_ON -> `rgb_out`=0. With `GAME_OVER_SCALE2X_EN` defined, `h_count`=229 and 230 give `x_count`=0 and 1 respectively.
